// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch sequencer and the instruction
// decoder of the CPU core.
//   - default program-memory address and data widths
//   - opcode nibble constants (bits [7:4] of the first instruction byte)
//   - the fetch sequencer state encoding
package cpu_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  // Sequencing-relevant opcodes.
  localparam logic [3:0] OP_LDI  = 4'h2;  // load immediate, two bytes
  localparam logic [3:0] OP_BZR  = 4'h7;  // branch-if-zero relative, one byte
  localparam logic [3:0] OP_JZ   = 4'hD;  // jump-if-zero absolute, two bytes
  localparam logic [3:0] OP_HALT = 4'hF;

  // Datapath opcodes: one byte, sequential as far as fetch is concerned.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_FETCH_IMM = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_BR   = 3'd4,
    ST_HALT      = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational opcode class decode, shared by the fetch
// sequencer and the instruction decoder.
// Ports:
//   op_nibble    in  4  opcode bits [7:4]
//   is_two_byte  out 1  instruction carries an immediate byte (LDI, JZ)
//   is_ctrl_flow out 1  instruction may redirect the PC (BZR, JZ)
//   is_halt      out 1  HALT opcode
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [3:0] op_nibble,
  output logic       is_two_byte,
  output logic       is_ctrl_flow,
  output logic       is_halt
);

  assign is_two_byte  = (op_nibble == OP_LDI) || (op_nibble == OP_JZ);
  assign is_ctrl_flow = (op_nibble == OP_BZR) || (op_nibble == OP_JZ);
  assign is_halt      = (op_nibble == OP_HALT);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch and sequencing controller for the
// program memory of the CPU core. Owns the PC, assembles one- and two-byte
// instructions and presents them to decode over valid/ready. Control-flow
// instructions stall fetch until the datapath resolves the branch.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   run          in   fetch enable, sampled only while idle
//   pm_addr      out  program memory address (the registered PC)
//   pm_data      in   combinational program memory read data for pm_addr
//   instr_valid  out  instruction presented to decode
//   instr_ready  in   decode accepts the instruction
//   instr_opcode out  first instruction byte
//   instr_imm    out  second byte of two-byte opcodes, else 0
//   instr_pc     out  address of the first instruction byte
//   br_resolve   in   one-cycle pulse: branch condition evaluated
//   br_taken     in   qualifies br_resolve
//   br_offset    in   forward offset for relative branches
//   halted       out  HALT opcode retired
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] pm_addr,
  input  logic [DATA_W-1:0] pm_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              br_resolve,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              halted
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] opcode_reg, opcode_next;
  logic [DATA_W-1:0] imm_reg, imm_next;
  logic [ADDR_W-1:0] ipc_reg, ipc_next;

  // One classifier serves both phases: in FETCH it looks at the byte coming
  // out of memory, afterwards at the captured opcode.
  logic [3:0] class_nibble;
  logic       is_two_byte, is_ctrl_flow, is_halt;

  assign class_nibble = (state_reg == ST_FETCH) ? pm_data[DATA_W-1 -: 4]
                                                : opcode_reg[DATA_W-1 -: 4];

  opcode_classifier u_classifier (
    .op_nibble    (class_nibble),
    .is_two_byte  (is_two_byte),
    .is_ctrl_flow (is_ctrl_flow),
    .is_halt      (is_halt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= RESET_PC;
      opcode_reg <= '0;
      imm_reg    <= '0;
      ipc_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      opcode_reg <= opcode_next;
      imm_reg    <= imm_next;
      ipc_reg    <= ipc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    opcode_next = opcode_reg;
    imm_next    = imm_reg;
    ipc_next    = ipc_reg;

    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end

      ST_FETCH: begin
        opcode_next = pm_data;
        ipc_next    = pc_reg;
        imm_next    = '0;
        pc_next     = pc_reg + ADDR_W'(1);
        state_next  = is_two_byte ? ST_FETCH_IMM : ST_ISSUE;
      end

      ST_FETCH_IMM: begin
        imm_next   = pm_data;
        pc_next    = pc_reg + ADDR_W'(1);
        state_next = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (instr_ready) begin
          if (is_halt)           state_next = ST_HALT;
          else if (is_ctrl_flow) state_next = ST_WAIT_BR;
          else                   state_next = ST_FETCH;
        end
      end

      ST_WAIT_BR: begin
        // pc already points past the instruction, which is the not-taken
        // target. Among control-flow opcodes only JZ is two-byte.
        if (br_resolve) begin
          if (br_taken) begin
            if (is_two_byte) pc_next = imm_reg[ADDR_W-1:0];
            else             pc_next = ipc_reg + br_offset;
          end
          state_next = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign pm_addr      = pc_reg;
  assign instr_valid  = (state_reg == ST_ISSUE);
  assign halted       = (state_reg == ST_HALT);
  assign instr_opcode = opcode_reg;
  assign instr_imm    = imm_reg;
  assign instr_pc     = ipc_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed program walk plus randomized programs, each
// instruction checked against an instruction-level model of the sequencer
// (expected fetch stream, latency, branch targets) kept in the bench.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic [4:0] pm_addr;
  logic [7:0] pm_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_imm;
  logic [4:0] instr_pc;
  logic       br_resolve;
  logic       br_taken;
  logic [4:0] br_offset;
  logic       halted;

  logic [7:0] pm [32];

  int checks = 0;
  int errors = 0;
  int mpc;          // model: address of next instruction to be issued
  bit mhalt;        // model: halt retired

  assign pm_data = pm[pm_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(5), .DATA_W(8), .RESET_PC(5'd0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .pm_addr      (pm_addr),
    .pm_data      (pm_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_imm    (instr_imm),
    .instr_pc     (instr_pc),
    .br_resolve   (br_resolve),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .halted       (halted)
  );

  function automatic bit op_two(input logic [7:0] op);
    return (op[7:4] == 4'h2) || (op[7:4] == 4'hD);
  endfunction
  function automatic bit op_ctrl(input logic [7:0] op);
    return (op[7:4] == 4'h7) || (op[7:4] == 4'hD);
  endfunction
  function automatic bit op_halt(input logic [7:0] op);
    return op[7:4] == 4'hF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_pm();
    for (int i = 0; i < 32; i++) pm[i] = 8'h00;
  endtask

  // Synchronised to a falling edge; reset asserted then released with run=0.
  task automatic do_reset();
    reset_n     = 1'b0;
    run         = 1'b0;
    instr_ready = 1'b1;
    br_resolve  = 1'b0;
    br_taken    = 1'b0;
    br_offset   = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    mpc   = 0;
    mhalt = 1'b0;
  endtask

  // Pulse run for one cycle; returns at the first falling edge after the
  // edge that leaves IDLE.
  task automatic start();
    run = 1'b1;
    cyc();
    run = 1'b0;
  endtask

  // Issue one instruction from the model's PC. Entry: first falling edge after
  // the triggering edge (run start, accept, or branch resolve). delay < 0
  // leaves the DUT waiting for a branch resolve.
  task automatic run_instr(input int stall, input bit taken, input int delay,
                           input logic [4:0] off);
    logic [7:0] eop, eimm;
    int epc, lat, len, n;
    bit two;
    epc  = mpc;
    eop  = pm[epc];
    two  = op_two(eop);
    eimm = two ? pm[(epc + 1) % 32] : 8'h00;
    lat  = two ? 3 : 2;
    len  = two ? 2 : 1;

    n = 1;
    while (instr_valid !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    check("issue_latency", n, lat);
    check("opcode", instr_opcode, eop);
    check("imm", instr_imm, eimm);
    check("instr_pc", instr_pc, epc);

    if (stall > 0) begin
      instr_ready = 1'b0;
      repeat (stall) begin
        br_resolve = 1'($urandom_range(0, 1));
        br_taken   = 1'b1;
        br_offset  = 5'd9;
        cyc();
        check("stall_valid", instr_valid, 1);
        check("stall_opcode", instr_opcode, eop);
        check("stall_imm", instr_imm, eimm);
        check("stall_pc", instr_pc, epc);
      end
      br_resolve = 1'b0;
      br_taken   = 1'b0;
    end

    instr_ready = 1'b1;
    cyc();
    $display("issue pc=%0d op=%02h imm=%02h stall=%0d", epc, eop, eimm, stall);

    if (op_halt(eop)) begin
      mhalt = 1'b1;
      repeat (3) begin
        check("halted", halted, 1);
        check("halt_no_valid", instr_valid, 0);
        cyc();
      end
      check("halt_pm_addr", pm_addr, (epc + 1) % 32);
    end else if (op_ctrl(eop)) begin
      check("wait_pm_addr", pm_addr, (epc + len) % 32);
      if (delay >= 0) begin
        for (int i = 0; i < delay; i++) begin
          check("wait_no_valid", instr_valid, 0);
          cyc();
        end
        check("wait_no_valid", instr_valid, 0);
        br_resolve = 1'b1;
        br_taken   = taken;
        br_offset  = off;
        cyc();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        if (!taken)               mpc = (epc + len) % 32;
        else if (eop[7:4] == 4'hD) mpc = int'(eimm[4:0]);
        else                      mpc = (epc + int'(off)) % 32;
        check("branch_target", pm_addr, mpc);
        $display("resolve pc=%0d taken=%0d off=%0d target=%0d", epc, taken, off, mpc);
      end
    end else begin
      mpc = (epc + len) % 32;
      check("next_pm_addr", pm_addr, mpc);
      check("not_halted", halted, 0);
    end
  endtask

  initial begin
    clear_pm();
    reset_n     = 1'b0;
    run         = 1'b0;
    instr_ready = 1'b1;
    br_resolve  = 1'b0;
    br_taken    = 1'b0;
    br_offset   = '0;

    // Reset values while held in reset.
    cyc();
    check("rst_pm_addr", pm_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", instr_opcode, 0);
    check("rst_imm", instr_imm, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_halted", halted, 0);
    reset_n = 1'b1;
    repeat (3) begin
      cyc();
      check("idle_valid", instr_valid, 0);
      check("idle_pm_addr", pm_addr, 0);
    end
    mpc   = 0;
    mhalt = 1'b0;

    // Directed program.
    pm[0]  = 8'h10; pm[1]  = 8'h41;
    pm[2]  = 8'h20; pm[3]  = 8'h01;
    pm[4]  = 8'hD0; pm[5]  = 8'h17;
    pm[21] = 8'h60; pm[22] = 8'hF0;
    pm[23] = 8'hD0; pm[24] = 8'h15;
    pm[25] = 8'h30; pm[26] = 8'h50;
    pm[27] = 8'h77;
    pm[29] = 8'hD0; pm[30] = 8'h1F;
    pm[31] = 8'h77;
    start();
    run_instr(0, 0, 0, 0);   // 0x10 @0
    run_instr(0, 0, 0, 0);   // 0x41 @1
    run_instr(0, 0, 0, 0);   // 0x20 0x01 @2
    run_instr(0, 1, 0, 0);   // JZ @4 taken -> 23
    run_instr(0, 0, 1, 0);   // JZ @23 not taken -> 25
    run_instr(0, 0, 0, 0);   // 0x30 @25
    run_instr(3, 0, 0, 0);   // 0x50 @26, backpressure
    run_instr(0, 1, 0, 5'd2); // BZR @27 +2 -> 29
    run_instr(0, 1, 0, 0);   // JZ @29 -> 31
    run_instr(0, 1, 2, 5'd3); // BZR @31 +3 -> 2
    run_instr(1, 0, 0, 0);   // 0x20 0x01 @2
    run_instr(0, 1, 0, 0);   // JZ @4 -> 23
    run_instr(0, 1, 5, 0);   // JZ @23 after 5 cycles -> 21
    run_instr(3, 0, 0, 0);   // 0x60 @21, backpressure
    run_instr(0, 0, 0, 0);   // HALT @22

    // Two-byte instruction at the last address takes its immediate from 0.
    do_reset();
    clear_pm();
    pm[0] = 8'hD0; pm[1] = 8'h1F; pm[2] = 8'hF0; pm[31] = 8'h2A;
    start();
    run_instr(0, 1, 0, 0);   // JZ -> 31
    run_instr(0, 0, 0, 0);   // LDI @31, imm from @0
    run_instr(0, 0, 0, 0);   // 0x1F @1
    run_instr(0, 0, 0, 0);   // HALT @2

    // Asynchronous reset while waiting for a branch resolve.
    do_reset();
    clear_pm();
    pm[0] = 8'h10; pm[1] = 8'h75;
    start();
    run_instr(0, 0, 0, 0);
    run_instr(0, 0, -1, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_pm_addr", pm_addr, 0);
    check("async_valid", instr_valid, 0);
    check("async_opcode", instr_opcode, 0);
    check("async_instr_pc", instr_pc, 0);
    check("async_halted", halted, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    br_resolve = 1'b1;       // ignored in IDLE
    br_taken   = 1'b1;
    br_offset  = 5'd7;
    repeat (4) begin
      cyc();
      br_resolve = 1'b0;
      check("post_rst_no_valid", instr_valid, 0);
      check("post_rst_pm_addr", pm_addr, 0);
    end
    br_taken = 1'b0;

    // Randomized programs.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int i = 0; i < 32; i++) pm[i] = 8'($urandom);
      start();
      for (int k = 0; k < 25 && !mhalt; k++) begin
        run_instr($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 5'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch and sequencing controller for the 32x8 program memory of the CPU core.
- Owns the program counter and drives the memory address. Assembles one- and two-byte instructions and hands each one to decode/execute over a valid/ready handshake.
- Stalls on control-flow instructions until the datapath resolves the branch condition, then redirects the PC.
- The program memory read is combinational: data for the driven address is valid in the same cycle.

Parameters:
- ADDR_W, 5, program-memory address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 8, instruction/byte width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable; sampled only in IDLE.
- pm_addr  out  ADDR_W  program memory address (registered PC).
- pm_data  in  DATA_W  program memory read data for pm_addr.
- instr_valid  out  1  instruction presented to decode.
- instr_ready  in  1  decode accepts the instruction.
- instr_opcode  out  DATA_W  first instruction byte.
- instr_imm  out  DATA_W  second byte for two-byte opcodes, else 0.
- instr_pc  out  ADDR_W  address of the first instruction byte.
- br_resolve  in  1  one-cycle pulse: branch condition evaluated.
- br_taken  in  1  qualifies br_resolve.
- br_offset  in  ADDR_W  register-supplied forward offset for relative branch.
- halted  out  1  HALT opcode retired.

Behaviour:
- Opcode class is decoded from opcode[7:4]:
  - 0x2 (load immediate): two-byte.
  - 0xD (jump-if-zero absolute): two-byte and control-flow.
  - 0x7 (branch-if-zero relative): one-byte and control-flow.
  - 0xF: halt.
  - All others: one-byte, sequential.
- States: IDLE, FETCH, FETCH_IMM, ISSUE, WAIT_BR, HALT.
- Reset (async) values: state=IDLE, pc=RESET_PC, pm_addr=RESET_PC, instr_valid=0, instr_opcode=0, instr_imm=0, instr_pc=0, halted=0.
- IDLE: when run=1, go to FETCH.
- FETCH:
  - Capture instr_opcode<=pm_data, instr_pc<=pc, instr_imm<=0; pc<=pc+1.
  - If two-byte, go to FETCH_IMM; else go to ISSUE.
- FETCH_IMM: capture instr_imm<=pm_data; pc<=pc+1; go to ISSUE.
- ISSUE:
  - instr_valid=1. Opcode, imm and pc are held stable while instr_ready=0.
  - On instr_valid&&instr_ready:
    - halt opcode: go to HALT.
    - control-flow opcode: go to WAIT_BR.
    - otherwise: go to FETCH.
- WAIT_BR:
  - instr_valid=0; wait for br_resolve.
  - Not taken: pc unchanged (already points past the instruction).
  - Taken, 0xD: pc<=instr_imm[ADDR_W-1:0].
  - Taken, 0x7: pc<=instr_pc+br_offset, modulo 2^ADDR_W.
  - Then go to FETCH.
- HALT: halted=1, instr_valid=0. Leaves only on reset.
- Latency and throughput:
  - One-byte instruction: valid 1 cycle after its FETCH cycle.
  - Two-byte instruction: valid 2 cycles after its FETCH cycle.
  - Peak throughput: one one-byte instruction per 2 cycles.
- pm_addr always equals pc (registered).
- PC increment wraps 31->0. A two-byte instruction at address 31 takes its immediate from address 0.
- br_resolve outside WAIT_BR is ignored.
- run deasserting after leaving IDLE has no effect.
- Asynchronous reset in any state, including mid-handshake or WAIT_BR, returns to IDLE with reset values. No instruction is re-issued.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode nibble constants (OP_LDI=4'h2, OP_BZR=4'h7, OP_JZ=4'hD, OP_HALT=4'hF, plus the datapath opcodes);
  - the state enum;
  - the ADDR_W/DATA_W defaults.
- One natural sub-module: opcode_classifier, a combinational block producing is_two_byte, is_ctrl_flow and is_halt from opcode[7:4]. It is reused by the decoder.

Test Plan:
- Reset: hold reset_n=0 -> all outputs at reset values. Release with run=0 -> stays IDLE, pm_addr=0, instr_valid=0.
- Straight line: PM[0]=0x10, PM[1]=0x41, ready=1, run=1 ->
  - first valid: opcode 0x10, pc 0;
  - second valid: opcode 0x41, pc 1, exactly 2 cycles later.
- Immediate: PM[2]=0x20, PM[3]=0x01 -> opcode 0x20, imm 0x01, pc 2; next FETCH pm_addr=4.
- Absolute jump: PM[23]=0xD0, PM[24]=0x15:
  - taken -> next FETCH pm_addr=21;
  - not taken -> pm_addr=25.
  - Resolve pulse delayed 5 cycles -> no valid during the wait.
- Relative branch: PM[27]=0x77, br_offset=2, taken -> pm_addr=29.
  - At pc 31 with offset 3 -> pm_addr=2 (wrap).
- Backpressure, halt and reset:
  - ready low 3 cycles -> valid, opcode, imm, pc stable.
  - Opcode 0xF0 accepted -> halted=1, no further valid.
  - reset_n pulsed in WAIT_BR -> IDLE, pc=0.
